adder_pc: RTL and testbench

//   Next-sequential-PC generator for the 16-bit single-cycle CPU: PC_Add_out = PC_out + 2.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/pc_sticky_flags.sv | 26 ++
 rtl/adder_pc.sv | 41 ++++
 tb/tb_adder_pc.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types for the 16-bit single-cycle datapath.
package cpu_pkg;
  localparam int PC_WIDTH = 16;
  localparam int PC_INC   = 2;

  typedef logic [15:0] pc_t;
endpackage : cpu_pkg

// File: rtl/pc_sticky_flags.sv
// Two-bit sticky diagnostic register: async active-low reset, synchronous clear,
// otherwise each bit accumulates its set condition.
module pc_sticky_flags (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic [1:0] i_set,
  output logic [1:0] o_flags
);

  logic [1:0] r_flags;

  // Clear outranks a simultaneous set so software sees a clean slate after clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 2'b00;
    end else if (i_clr) begin
      r_flags <= 2'b00;
    end else begin
      r_flags <= r_flags | i_set;
    end
  end

  assign o_flags = r_flags;

endmodule : pc_sticky_flags

// File: rtl/adder_pc.sv
// Next-sequential-PC generator: PC_Add_out = PC_out + PC_INC, combinational,
// plus sticky wrap / misaligned-fetch flags for debug trace.
module adder_pc
  import cpu_pkg::*;
#(
  parameter int P_PC_WIDTH = PC_WIDTH,
  parameter int P_PC_INC   = PC_INC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_PC_WIDTH-1:0] PC_out,
  output logic [P_PC_WIDTH-1:0] PC_Add_out,
  output logic                  pc_wrap,
  output logic                  pc_misaligned,
  output logic                  wrap_seen,
  output logic                  misalign_seen,
  input  logic                  clr_sticky
);

  logic [1:0] w_flags;

  // Odd PCs are deliberately not realigned; the carry-out is the wrap indication.
  assign {pc_wrap, PC_Add_out} = {1'b0, PC_out} + (P_PC_WIDTH + 1)'(P_PC_INC);
  assign pc_misaligned         = PC_out[0];

  pc_sticky_flags u_flags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clr_sticky),
    .i_set   ({misalign_seen_cond(pc_misaligned), pc_wrap}),
    .o_flags (w_flags)
  );

  assign wrap_seen     = w_flags[0];
  assign misalign_seen = w_flags[1];

  function automatic logic misalign_seen_cond(input logic a);
    return a;
  endfunction

endmodule : adder_pc

// File: tb/tb_adder_pc.sv
// Directed-vector bench for adder_pc: combinational add/wrap/misalign results
// and sticky-flag reset, set and clear behaviour.
`timescale 1ns/1ps
module tb_adder_pc;

  logic        clk;
  logic        rst_n;
  logic [15:0] PC_out;
  logic [15:0] PC_Add_out;
  logic        pc_wrap;
  logic        pc_misaligned;
  logic        wrap_seen;
  logic        misalign_seen;
  logic        clr_sticky;

  int total_cnt;
  int bad_cnt;

  adder_pc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_out        (PC_out),
    .PC_Add_out    (PC_Add_out),
    .pc_wrap       (pc_wrap),
    .pc_misaligned (pc_misaligned),
    .wrap_seen     (wrap_seen),
    .misalign_seen (misalign_seen),
    .clr_sticky    (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // PC in, expected next PC, expected wrap, expected misaligned
  typedef struct {
    logic [15:0] pc;
    logic [15:0] nxt;
    logic        wrap;
    logic        mis;
  } vec_t;

  vec_t vecs[6];

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    rst_n      = 1'b0;
    clr_sticky = 1'b0;
    PC_out     = 16'h0000;

    vecs[0] = '{16'h0000, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h1236, 1'b0, 1'b0};
    vecs[2] = '{16'h0001, 16'h0003, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFE, 16'h8000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFE, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b1, 1'b1};

    // Outputs valid and flags held low during reset
    #2;
    chk("rst_wrap_seen", 32'(wrap_seen), 32'd0);
    chk("rst_misalign_seen", 32'(misalign_seen), 32'd0);
    PC_out = 16'hFFFF;
    #1;
    chk("rst_add_valid", 32'(PC_Add_out), 32'h0001);
    @(posedge clk); #1;
    chk("rst_hold_wrap_seen", 32'(wrap_seen), 32'd0);

    // Combinational table, reset still asserted so flags stay quiet
    for (int i = 0; i < 6; i++) begin
      PC_out = vecs[i].pc;
      #1;
      chk($sformatf("add[%0h]", vecs[i].pc), 32'(PC_Add_out), 32'(vecs[i].nxt));
      chk($sformatf("wrap[%0h]", vecs[i].pc), 32'(pc_wrap), 32'(vecs[i].wrap));
      chk($sformatf("mis[%0h]", vecs[i].pc), 32'(pc_misaligned), 32'(vecs[i].mis));
    end

    // Release reset away from the edge with a benign PC
    PC_out = 16'h0000;
    #1 rst_n = 1'b1;
    #10;
    chk("t1_add", 32'(PC_Add_out), 32'h0002);
    @(posedge clk); #1;
    PC_out = 16'h1234;
    @(posedge clk); #1;
    chk("t2_no_flags", 32'({wrap_seen, misalign_seen}), 32'd0);

    PC_out = 16'hFFFE;
    #1;
    chk("t3_add", 32'(PC_Add_out), 32'h0000);
    @(posedge clk); #1;
    chk("t3_wrap_seen", 32'(wrap_seen), 32'd1);
    chk("t3_misalign_clear", 32'(misalign_seen), 32'd0);

    PC_out = 16'hFFFF;
    @(posedge clk); #1;
    chk("t4_misalign_seen", 32'(misalign_seen), 32'd1);
    chk("t4_wrap_held", 32'(wrap_seen), 32'd1);

    // Async reset mid-cycle clears flags immediately
    PC_out = 16'h0100;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_flags_async", 32'({wrap_seen, misalign_seen}), 32'd0);
    chk("t5_add_tracks", 32'(PC_Add_out), 32'h0102);
    #1 rst_n = 1'b1;

    PC_out = 16'hFFFF;
    @(posedge clk); #1;
    chk("t6_flags_set", 32'({wrap_seen, misalign_seen}), 32'b11);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    chk("t6_clear_wins", 32'({wrap_seen, misalign_seen}), 32'b00);
    clr_sticky = 1'b0;
    @(posedge clk); #1;
    chk("t6_reset_again", 32'({wrap_seen, misalign_seen}), 32'b11);

    // Clear with a clean PC stays clear afterwards
    PC_out     = 16'h0040;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(posedge clk); #1;
    chk("t7_stay_clear", 32'({wrap_seen, misalign_seen}), 32'b00);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule : tb_adder_pc
